// File: rtl/valid_array_ctrl_pkg.sv
// Shared definitions for the valid-array sequencer.
//   va_state_t          : controller states (idle arbitration / flush walk)
//   WAY_MASK_ALL_ONES   : all-ways mask; slice to the instance's way count
//   VALUE_VALID/INVALID : encodings driven on the array write-value line
//   REQ_*               : requester slots on the shared priority arbiter
package valid_array_ctrl_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } va_state_t;

    localparam int unsigned MAX_WAYS = 64;
    localparam logic [MAX_WAYS-1:0] WAY_MASK_ALL_ONES = '1;

    localparam logic VALUE_VALID   = 1'b1;
    localparam logic VALUE_INVALID = 1'b0;

    // Slot 0 has the highest priority on the arbiter.
    localparam int unsigned REQ_INV    = 0;
    localparam int unsigned REQ_FILL   = 1;
    localparam int unsigned REQ_LOOKUP = 2;
    localparam int unsigned NUM_REQ    = 3;

endpackage

// File: rtl/fixed_priority_arbiter.sv
// Fixed-priority arbiter, bit 0 highest priority.
//   req : request vector
//   gnt : one-hot grant (all zero when no request)
module fixed_priority_arbiter #(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    // Isolate the lowest set bit: req & -req.
    assign gnt = req & (~req + NUM_REQ'(1));

endmodule

// File: rtl/valid_array_ctrl.sv
// Sequencer/arbiter in front of the L1 valid array's single access port.
// Shares the port between invalidate, fill and lookup (that priority) and
// runs a full-array flush walk after reset and on request.
//   clk_in, reset_in (async, active low)
//   lookup_* : read a set, response one cycle after grant
//   fill_*   : set one-hot way valid
//   inv_*    : clear masked ways
//   flush_*  : start / busy / done of the flush walk
//   va_*     : array access port (combinational drive, read data in)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | arbitrate requests; flush start writes set 0 in this state
// ST_FLUSH | walk sets 1..NUMBER_SETS-1 clearing all ways, grants held
module valid_array_ctrl
    import valid_array_ctrl_pkg::*;
#(
    parameter int unsigned SINGLE_ELEMENT_SIZE_IN_BITS = 8,
    parameter int unsigned NUMBER_SETS                 = 64,
    parameter int unsigned NUMBER_WAYS                 = 16,
    parameter int unsigned SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS),
    parameter bit          FLUSH_ON_RESET              = 1'b1
) (
    input  logic                                                clk_in,
    input  logic                                                reset_in,
    input  logic                                                lookup_req_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                    lookup_set_in,
    output logic                                                lookup_gnt_out,
    output logic                                                lookup_rsp_valid_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS*NUMBER_WAYS-1:0]  lookup_rsp_out,
    input  logic                                                fill_req_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                    fill_set_in,
    input  logic [NUMBER_WAYS-1:0]                              fill_way_in,
    output logic                                                fill_gnt_out,
    input  logic                                                inv_req_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                    inv_set_in,
    input  logic [NUMBER_WAYS-1:0]                              inv_way_in,
    output logic                                                inv_gnt_out,
    input  logic                                                flush_req_in,
    output logic                                                flush_busy_out,
    output logic                                                flush_done_out,
    output logic                                                va_access_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]                    va_set_addr_out,
    output logic                                                va_write_en_out,
    output logic [NUMBER_WAYS-1:0]                              va_way_select_out,
    output logic                                                va_write_value_out,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS*NUMBER_WAYS-1:0]  va_read_valid_in
);

    localparam logic [NUMBER_WAYS-1:0] WAYS_ALL = WAY_MASK_ALL_ONES[NUMBER_WAYS-1:0];
    localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET =
        SET_PTR_WIDTH_IN_BITS'(NUMBER_SETS - 1);

    va_state_t                        state;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] flush_cnt;
    logic                             flush_pending;
    logic                             rsp_valid_q;
    logic                             flush_done_q;

    logic                             flush_start;
    logic                             flush_active;
    logic                             last_set;
    logic [NUM_REQ-1:0]               arb_req;
    logic [NUM_REQ-1:0]               arb_gnt;

    // Combinational outputs are qualified with reset so the port is quiet
    // while reset is held, even though the pending flag is already armed.
    assign flush_start  = reset_in && (state == ST_IDLE) && (flush_pending || flush_req_in);
    assign flush_active = reset_in && ((state == ST_FLUSH) || flush_start);
    assign last_set     = (flush_cnt == LAST_SET);

    always_comb begin
        arb_req             = '0;
        arb_req[REQ_INV]    = inv_req_in;
        arb_req[REQ_FILL]   = fill_req_in;
        arb_req[REQ_LOOKUP] = lookup_req_in;
        if (!reset_in || flush_active) begin
            arb_req = '0;
        end
    end

    fixed_priority_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req (arb_req),
        .gnt (arb_gnt)
    );

    assign inv_gnt_out    = arb_gnt[REQ_INV];
    assign fill_gnt_out   = arb_gnt[REQ_FILL];
    assign lookup_gnt_out = arb_gnt[REQ_LOOKUP];

    // flush_cnt is 0 in ST_IDLE, so the start cycle writes set 0.
    always_comb begin
        va_access_en_out   = 1'b0;
        va_write_en_out    = 1'b0;
        va_set_addr_out    = '0;
        va_way_select_out  = '0;
        va_write_value_out = VALUE_INVALID;
        if (flush_active) begin
            va_access_en_out   = 1'b1;
            va_write_en_out    = 1'b1;
            va_set_addr_out    = flush_cnt;
            va_way_select_out  = WAYS_ALL;
            va_write_value_out = VALUE_INVALID;
        end else if (arb_gnt[REQ_INV]) begin
            va_access_en_out   = 1'b1;
            va_write_en_out    = 1'b1;
            va_set_addr_out    = inv_set_in;
            va_way_select_out  = inv_way_in;
            va_write_value_out = VALUE_INVALID;
        end else if (arb_gnt[REQ_FILL]) begin
            va_access_en_out   = 1'b1;
            va_write_en_out    = 1'b1;
            va_set_addr_out    = fill_set_in;
            va_way_select_out  = fill_way_in;
            va_write_value_out = VALUE_VALID;
        end else if (arb_gnt[REQ_LOOKUP]) begin
            va_access_en_out   = 1'b1;
            va_write_en_out    = 1'b0;
            va_set_addr_out    = lookup_set_in;
            va_way_select_out  = WAYS_ALL;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state         <= ST_IDLE;
            flush_cnt     <= '0;
            flush_pending <= FLUSH_ON_RESET;
            rsp_valid_q   <= 1'b0;
            flush_done_q  <= 1'b0;
        end else begin
            rsp_valid_q  <= arb_gnt[REQ_LOOKUP];
            flush_done_q <= (state == ST_FLUSH) && last_set;
            case (state)
                ST_IDLE: begin
                    if (flush_start) begin
                        flush_pending <= 1'b0;
                        flush_cnt     <= flush_cnt + SET_PTR_WIDTH_IN_BITS'(1);
                        state         <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // A request during a walk queues exactly one more walk;
                    // it starts from ST_IDLE on the next cycle.
                    if (flush_req_in) begin
                        flush_pending <= 1'b1;
                    end
                    if (last_set) begin
                        flush_cnt <= '0;
                        state     <= ST_IDLE;
                    end else begin
                        flush_cnt <= flush_cnt + SET_PTR_WIDTH_IN_BITS'(1);
                    end
                end
                default: begin
                    flush_cnt <= '0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign lookup_rsp_valid_out = rsp_valid_q;
    assign lookup_rsp_out       = rsp_valid_q ? va_read_valid_in : '0;
    assign flush_busy_out       = flush_active;
    assign flush_done_out       = flush_done_q;

endmodule

// File: tb/tb_valid_array_ctrl.sv
module tb_valid_array_ctrl;

    localparam int NS = 4;
    localparam int NW = 4;
    localparam int EW = 1;
    localparam int SW = 2;
    localparam int DW = EW * NW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          lookup_req = 1'b0;
    logic [SW-1:0] lookup_set = '0;
    logic          lookup_gnt;
    logic          lookup_rsp_valid;
    logic [DW-1:0] lookup_rsp;
    logic          fill_req = 1'b0;
    logic [SW-1:0] fill_set = '0;
    logic [NW-1:0] fill_way = '0;
    logic          fill_gnt;
    logic          inv_req = 1'b0;
    logic [SW-1:0] inv_set = '0;
    logic [NW-1:0] inv_way = '0;
    logic          inv_gnt;
    logic          flush_req = 1'b0;
    logic          flush_busy;
    logic          flush_done;
    logic          va_access_en;
    logic [SW-1:0] va_set_addr;
    logic          va_write_en;
    logic [NW-1:0] va_way_select;
    logic          va_write_value;
    logic [DW-1:0] va_read_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    valid_array_ctrl #(
        .SINGLE_ELEMENT_SIZE_IN_BITS (EW),
        .NUMBER_SETS                 (NS),
        .NUMBER_WAYS                 (NW),
        .SET_PTR_WIDTH_IN_BITS       (SW),
        .FLUSH_ON_RESET              (1'b1)
    ) dut (
        .clk_in               (clk),
        .reset_in             (rst_n),
        .lookup_req_in        (lookup_req),
        .lookup_set_in        (lookup_set),
        .lookup_gnt_out       (lookup_gnt),
        .lookup_rsp_valid_out (lookup_rsp_valid),
        .lookup_rsp_out       (lookup_rsp),
        .fill_req_in          (fill_req),
        .fill_set_in          (fill_set),
        .fill_way_in          (fill_way),
        .fill_gnt_out         (fill_gnt),
        .inv_req_in           (inv_req),
        .inv_set_in           (inv_set),
        .inv_way_in           (inv_way),
        .inv_gnt_out          (inv_gnt),
        .flush_req_in         (flush_req),
        .flush_busy_out       (flush_busy),
        .flush_done_out       (flush_done),
        .va_access_en_out     (va_access_en),
        .va_set_addr_out      (va_set_addr),
        .va_write_en_out      (va_write_en),
        .va_way_select_out    (va_way_select),
        .va_write_value_out   (va_write_value),
        .va_read_valid_in     (va_read_valid)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Initial array contents, shared by the environment array and the model.
    logic [DW-1:0] seed_mem [NS];

    // Environment: write-first valid array with one-cycle read latency.
    logic [DW-1:0] arr [NS];
    logic          arr_seeded = 1'b0;
    logic [DW-1:0] arr_rdata = '0;
    assign va_read_valid = arr_rdata;

    always @(posedge clk) begin
        if (!arr_seeded) begin
            for (int i = 0; i < NS; i++) arr[i] <= seed_mem[i];
            arr_seeded <= 1'b1;
        end else if (va_access_en) begin
            if (va_write_en)
                arr[va_set_addr] <= va_write_value ? (arr[va_set_addr] | va_way_select)
                                                   : (arr[va_set_addr] & ~va_way_select);
            else
                arr_rdata <= arr[va_set_addr];
        end
    end

    // Behavioural model: a walk is "writes remaining", flush requests queue
    // one extra walk, arbitration is a plain priority if-chain.
    int            m_left;
    logic          m_pending;
    logic          m_done;
    logic          m_rsp_v;
    logic [DW-1:0] m_rsp_d;
    logic          m_g_inv, m_g_fill, m_g_lk;
    logic [DW-1:0] exp_mem [NS];
    logic          mem_seeded = 1'b0;

    logic          exp_start, exp_busy;
    int            exp_wset;
    logic          exp_g_inv, exp_g_fill, exp_g_lk;
    logic          exp_access, exp_we, exp_val;
    logic [SW-1:0] exp_set;
    logic [NW-1:0] exp_way;

    always_comb begin
        exp_start  = 1'b0;
        exp_busy   = 1'b0;
        exp_wset   = 0;
        exp_g_inv  = 1'b0;
        exp_g_fill = 1'b0;
        exp_g_lk   = 1'b0;
        exp_access = 1'b0;
        exp_we     = 1'b0;
        exp_val    = 1'b0;
        exp_set    = '0;
        exp_way    = '0;
        if (rst_n) begin
            exp_start = (m_left == 0) && (m_pending || flush_req);
            exp_busy  = (m_left > 0) || exp_start;
            exp_wset  = exp_start ? 0 : NS - m_left;
            if (exp_busy) begin
                exp_access = 1'b1;
                exp_we     = 1'b1;
                exp_set    = SW'(exp_wset);
                exp_way    = '1;
                exp_val    = 1'b0;
            end else if (inv_req) begin
                exp_g_inv  = 1'b1;
                exp_access = 1'b1;
                exp_we     = 1'b1;
                exp_set    = inv_set;
                exp_way    = inv_way;
                exp_val    = 1'b0;
            end else if (fill_req) begin
                exp_g_fill = 1'b1;
                exp_access = 1'b1;
                exp_we     = 1'b1;
                exp_set    = fill_set;
                exp_way    = fill_way;
                exp_val    = 1'b1;
            end else if (lookup_req) begin
                exp_g_lk   = 1'b1;
                exp_access = 1'b1;
                exp_set    = lookup_set;
                exp_way    = '1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left    <= 0;
            m_pending <= 1'b1;
            m_done    <= 1'b0;
            m_rsp_v   <= 1'b0;
            m_rsp_d   <= '0;
            m_g_inv   <= 1'b0;
            m_g_fill  <= 1'b0;
            m_g_lk    <= 1'b0;
            if (!mem_seeded) begin
                for (int i = 0; i < NS; i++) exp_mem[i] <= seed_mem[i];
                mem_seeded <= 1'b1;
            end
        end else begin
            if (exp_start) m_left <= NS - 1;
            else if (m_left > 0) m_left <= m_left - 1;
            if (exp_start) m_pending <= 1'b0;
            else if (m_left > 0 && flush_req) m_pending <= 1'b1;
            m_done   <= exp_busy && (exp_wset == NS - 1);
            m_rsp_v  <= exp_g_lk;
            if (exp_g_lk) m_rsp_d <= exp_mem[lookup_set];
            m_g_inv  <= exp_g_inv;
            m_g_fill <= exp_g_fill;
            m_g_lk   <= exp_g_lk;
            if (exp_busy) exp_mem[exp_set] <= '0;
            else if (exp_g_inv) exp_mem[inv_set] <= exp_mem[inv_set] & ~inv_way;
            else if (exp_g_fill) exp_mem[fill_set] <= exp_mem[fill_set] | fill_way;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_outputs", 64'({lookup_gnt, lookup_rsp_valid, lookup_rsp, fill_gnt, inv_gnt,
                                   flush_busy, flush_done, va_access_en, va_set_addr,
                                   va_write_en, va_way_select, va_write_value}), 64'(0));
        end else begin
            chk("mon_busy",       64'(flush_busy),       64'(exp_busy));
            chk("mon_inv_gnt",    64'(inv_gnt),          64'(exp_g_inv));
            chk("mon_fill_gnt",   64'(fill_gnt),         64'(exp_g_fill));
            chk("mon_lookup_gnt", 64'(lookup_gnt),       64'(exp_g_lk));
            chk("mon_access_en",  64'(va_access_en),     64'(exp_access));
            chk("mon_write_en",   64'(va_write_en),      64'(exp_we));
            if (exp_access) begin
                chk("mon_set_addr",   64'(va_set_addr),   64'(exp_set));
                chk("mon_way_select", 64'(va_way_select), 64'(exp_way));
            end
            if (exp_we) chk("mon_write_value", 64'(va_write_value), 64'(exp_val));
            chk("mon_rsp_valid",  64'(lookup_rsp_valid), 64'(m_rsp_v));
            chk("mon_flush_done", 64'(flush_done),       64'(m_done));
            if (m_rsp_v) chk("mon_rsp_data", 64'(lookup_rsp), 64'(m_rsp_d));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n_done;

    initial begin
        for (int i = 0; i < NS; i++) seed_mem[i] = DW'($urandom);

        // 1: flush after reset release, then lookup of set 2
        repeat (3) tick();
        rst_n = 1'b1;
        for (int k = 0; k < NS; k++) begin
            @(negedge clk);
            chk("t1_busy",  64'(flush_busy),     64'(1));
            chk("t1_set",   64'(va_set_addr),    64'(k));
            chk("t1_way",   64'(va_way_select),  64'(4'b1111));
            chk("t1_value", 64'(va_write_value), 64'(0));
            tick();
        end
        @(negedge clk);
        chk("t1_done",     64'(flush_done), 64'(1));
        chk("t1_busy_end", 64'(flush_busy), 64'(0));
        tick();
        lookup_req = 1'b1; lookup_set = 2'd2;
        @(negedge clk);
        chk("t1_lk_gnt", 64'(lookup_gnt), 64'(1));
        tick();
        lookup_req = 1'b0;
        @(negedge clk);
        chk("t1_rsp_valid", 64'(lookup_rsp_valid), 64'(1));
        chk("t1_rsp",       64'(lookup_rsp),       64'(4'b0000));

        // 2: fill set 1 way 2, lookup set 1 next cycle
        tick();
        fill_req = 1'b1; fill_set = 2'd1; fill_way = 4'b0100;
        @(negedge clk);
        chk("t2_fill_gnt", 64'(fill_gnt), 64'(1));
        tick();
        fill_req = 1'b0; lookup_req = 1'b1; lookup_set = 2'd1;
        @(negedge clk);
        chk("t2_fill_gnt_off", 64'(fill_gnt),   64'(0));
        chk("t2_lk_gnt",       64'(lookup_gnt), 64'(1));
        tick();
        lookup_req = 1'b0;
        @(negedge clk);
        chk("t2_rsp_valid", 64'(lookup_rsp_valid), 64'(1));
        chk("t2_rsp",       64'(lookup_rsp),       64'(4'b0100));

        // 3: all three requesters at once on set 3
        tick();
        inv_req = 1'b1; inv_set = 2'd3; inv_way = 4'b0011;
        fill_req = 1'b1; fill_set = 2'd3; fill_way = 4'b1000;
        lookup_req = 1'b1; lookup_set = 2'd3;
        @(negedge clk);
        chk("t3_c1_gnts", 64'({inv_gnt, fill_gnt, lookup_gnt}), 64'(3'b100));
        tick();
        inv_req = 1'b0;
        @(negedge clk);
        chk("t3_c2_gnts", 64'({inv_gnt, fill_gnt, lookup_gnt}), 64'(3'b010));
        tick();
        fill_req = 1'b0;
        @(negedge clk);
        chk("t3_c3_gnts", 64'({inv_gnt, fill_gnt, lookup_gnt}), 64'(3'b001));
        tick();
        lookup_req = 1'b0;
        @(negedge clk);
        chk("t3_rsp", 64'(lookup_rsp), 64'(4'b1000));

        // 4: flush pulse while a lookup is held
        tick();
        flush_req = 1'b1; lookup_req = 1'b1; lookup_set = 2'd1;
        for (int k = 0; k < NS; k++) begin
            @(negedge clk);
            chk("t4_lk_stall", 64'(lookup_gnt), 64'(0));
            chk("t4_busy",     64'(flush_busy), 64'(1));
            tick();
            flush_req = 1'b0;
        end
        @(negedge clk);
        chk("t4_done",   64'(flush_done), 64'(1));
        chk("t4_lk_gnt", 64'(lookup_gnt), 64'(1));
        tick();
        lookup_req = 1'b0;
        @(negedge clk);
        chk("t4_rsp_valid", 64'(lookup_rsp_valid), 64'(1));
        chk("t4_rsp",       64'(lookup_rsp),       64'(4'b0000));

        // 5: flush request during an active walk
        n_done = 0;
        tick();
        flush_req = 1'b1;
        for (int c = 0; c < 2 * NS; c++) begin
            @(negedge clk);
            chk("t5_busy", 64'(flush_busy), 64'(1));
            if (flush_done) n_done++;
            tick();
            flush_req = (c == 0);
        end
        @(negedge clk);
        chk("t5_busy_end", 64'(flush_busy), 64'(0));
        if (flush_done) n_done++;
        chk("t5_done_count", 64'(n_done), 64'(2));

        // 6: reset during the walk at set 2
        tick();
        flush_req = 1'b1;
        @(negedge clk);
        tick();
        flush_req = 1'b0;
        tick();
        @(negedge clk);
        chk("t6_set_before", 64'(va_set_addr), 64'(2));
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_busy",   64'(flush_busy),   64'(0));
        chk("t6_async_access", 64'(va_access_en), 64'(0));
        chk("t6_async_set",    64'(va_set_addr),  64'(0));
        chk("t6_async_way",    64'(va_way_select), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < NS; k++) begin
            @(negedge clk);
            chk("t6_busy", 64'(flush_busy),  64'(1));
            chk("t6_set",  64'(va_set_addr), 64'(k));
            tick();
        end
        @(negedge clk);
        chk("t6_done", 64'(flush_done), 64'(1));

        // Randomized traffic checked by the model
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (inv_req && m_g_inv) inv_req = 1'b0;
            else if (!inv_req && $urandom_range(0, 3) == 0) begin
                inv_req = 1'b1;
                inv_set = SW'($urandom_range(0, NS - 1));
                inv_way = NW'($urandom);
            end
            if (fill_req && m_g_fill) fill_req = 1'b0;
            else if (!fill_req && $urandom_range(0, 2) == 0) begin
                fill_req = 1'b1;
                fill_set = SW'($urandom_range(0, NS - 1));
                fill_way = NW'(1) << $urandom_range(0, NW - 1);
            end
            if (lookup_req && m_g_lk) lookup_req = 1'b0;
            else if (!lookup_req && $urandom_range(0, 1) == 0) begin
                lookup_req = 1'b1;
                lookup_set = SW'($urandom_range(0, NS - 1));
            end
            flush_req = !flush_req && ($urandom_range(0, 40) == 0);
        end
        tick();
        flush_req = 1'b0; inv_req = 1'b0; fill_req = 1'b0; lookup_req = 1'b0;
        repeat (NS + 3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
